// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: N-way round-robin burst arbiter driving the select of a shared muxN.
// A grant is registered one cycle after a request and then held for the whole burst.
// The burst ends on Last, on the beat limit, or when the owner withdraws its request.
// Each burst is followed by exactly one IDLE bubble cycle.
module rr_sel_arbiter #(
   parameter  int N        = 4,
   parameter  int MAXBEATS = 8,
   localparam int SELW     = $clog2(N),
   localparam int CW       = ($clog2(MAXBEATS + 1) < 1) ? 1 : $clog2(MAXBEATS + 1)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [N-1:0]    Req,
   input  logic [N-1:0]    Last,
   input  logic            Ready,
   output logic [N-1:0]    Gnt,
   output logic [SELW-1:0] Sel,
   output logic            Valid,
   output logic [CW-1:0]   BeatCount,
   output logic            Timeout
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Count value on which the final permitted beat transfers (unused when the limit is off).
   localparam logic [CW-1:0]   BEAT_LIMIT = (MAXBEATS == 0) ? CW'(0) : CW'(MAXBEATS - 1);
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
   localparam logic [SELW-1:0] PTR_RESET  = SELW'(N - 1);
   localparam bit              LIMIT_ON   = (MAXBEATS != 0);

   logic [0:0]      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   logic            busy_s;
   logic            valid_s;
   logic            xfer_s;
   logic            found_s;
   logic [SELW-1:0] win_s;

   assign busy_s  = (state_q == ST_BUSY);
   // Valid is forced low while reset is asserted so no beat is ever offered during reset.
   assign valid_s = resetn & busy_s & Req[sel_q];
   assign xfer_s  = valid_s & Ready;

   // Round-robin search starting just after the pointer; first set request bit wins.
   always_comb begin
      int              idx;
      logic [SELW-1:0] cand;
      found_s = 1'b0;
      win_s   = ptr_q;
      idx     = 0;
      cand    = ptr_q;
      for (int i = 1; i <= N; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N) begin
            idx = idx - N;
         end else begin
            idx = idx;
         end
         cand = SELW'(idx);
         if (!found_s && Req[cand]) begin
            found_s = 1'b1;
            win_s   = cand;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic for the IDLE/BUSY burst FSM and its datapath registers.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d        = ST_BUSY;
               gnt_d          = {N{1'b0}};
               gnt_d[win_s]   = 1'b1;
               sel_d          = win_s;
               cnt_d          = {CW{1'b0}};
            end else begin
               gnt_d          = {N{1'b0}};
            end
         end
         ST_BUSY: begin
            if (!Req[sel_q]) begin
               // Owner withdrew: release without waiting for a beat.
               state_d = ST_IDLE;
               gnt_d   = {N{1'b0}};
               cnt_d   = {CW{1'b0}};
               ptr_d   = sel_q;
            end else if (xfer_s && Last[sel_q]) begin
               // Last takes priority over a coincident beat limit, so no Timeout here.
               state_d = ST_IDLE;
               gnt_d   = {N{1'b0}};
               cnt_d   = {CW{1'b0}};
               ptr_d   = sel_q;
            end else if (xfer_s && LIMIT_ON && (cnt_q == BEAT_LIMIT)) begin
               state_d   = ST_IDLE;
               gnt_d     = {N{1'b0}};
               cnt_d     = {CW{1'b0}};
               ptr_d     = sel_q;
               timeout_d = 1'b1;
            end else if (xfer_s) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = {N{1'b0}};
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset aborts any burst outright.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         gnt_q     <= {N{1'b0}};
         sel_q     <= {SELW{1'b0}};
         ptr_q     <= PTR_RESET;
         cnt_q     <= {CW{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign Gnt       = gnt_q;
   assign Sel       = sel_q;
   assign Valid     = valid_s;
   assign BeatCount = cnt_q;
   assign Timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (N=4, MAXBEATS=8): a vector table for reset,
// rotation, burst hold and withdrawal, plus hand sequences for the beat limit,
// owner withdrawal and reset in the middle of a burst.
module tb_rr_sel_arbiter;

   logic       clk;
   logic       resetn;
   logic [3:0] req;
   logic [3:0] last;
   logic       ready;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic [3:0] beat_count;
   logic       timeout;

   int checks;
   int failures;

   typedef struct {
      logic       rn;
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic       ev;
      logic [3:0] eg;
      logic [1:0] es;
      logic [3:0] ec;
      logic       et;
   } vec_t;

   vec_t tbl [24];

   rr_sel_arbiter #(.N(4), .MAXBEATS(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .Req       (req),
      .Last      (last),
      .Ready     (ready),
      .Gnt       (gnt),
      .Sel       (sel),
      .Valid     (valid),
      .BeatCount (beat_count),
      .Timeout   (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic rn, logic [3:0] rq, logic [3:0] ls, logic rd,
                               logic ev, logic [3:0] eg, logic [1:0] es,
                               logic [3:0] ec, logic et);
      vec_t v;
      v.rn = rn; v.req = rq; v.last = ls; v.rdy = rd;
      v.ev = ev; v.eg = eg; v.es = es; v.ec = ec; v.et = et;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check Valid before the rising
   // edge, then check the registered outputs just after it.
   task automatic step(input vec_t v, input int idx);
      @(negedge clk);
      resetn = v.rn;
      req    = v.req;
      last   = v.last;
      ready  = v.rdy;
      #1;
      chk("valid", idx, 32'(valid), 32'(v.ev));
      @(posedge clk);
      #1;
      chk("gnt", idx, 32'(gnt), 32'(v.eg));
      chk("sel", idx, 32'(sel), 32'(v.es));
      chk("beatcount", idx, 32'(beat_count), 32'(v.ec));
      chk("timeout", idx, 32'(timeout), 32'(v.et));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetn   = 1'b0;
      req      = 4'b1111;
      last     = 4'b1111;
      ready    = 1'b1;

      //               rn    req      last     rdy   ev    gnt      sel    cnt     to
      // reset held three cycles with all requests up
      tbl[0]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);
      tbl[1]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);
      tbl[2]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);
      // strict rotation of single-beat bursts with a bubble between them
      tbl[3]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 4'd0, 1'b0);
      tbl[4]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 4'd0, 1'b0);
      tbl[5]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1, 4'd0, 1'b0);
      tbl[6]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd1, 4'd0, 1'b0);
      tbl[7]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 4'd0, 1'b0);
      tbl[8]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 4'd0, 1'b0);
      tbl[9]  = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3, 4'd0, 1'b0);
      tbl[10] = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd3, 4'd0, 1'b0);
      tbl[11] = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 4'd0, 1'b0);
      tbl[12] = mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 4'd0, 1'b0);
      // burst hold on requester 2 with Ready toggling; Last on the fourth beat
      tbl[13] = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 4'd0, 1'b0);
      tbl[14] = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 4'd1, 1'b0);
      tbl[15] = mk(1'b1, 4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 4'd1, 1'b0);
      tbl[16] = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 4'd2, 1'b0);
      tbl[17] = mk(1'b1, 4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 4'd2, 1'b0);
      tbl[18] = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 4'd3, 1'b0);
      tbl[19] = mk(1'b1, 4'b0101, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 4'd3, 1'b0);
      tbl[20] = mk(1'b1, 4'b0101, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, 4'd0, 1'b0);
      tbl[21] = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 4'd0, 1'b0);
      // owner 0 withdraws, then nobody requests
      tbl[22] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);
      tbl[23] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         step(tbl[i], i);
      end

      // Beat limit: requester 1, Last low, 8 transfers then a Timeout bubble.
      step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 4'd0, 1'b0), 100);
      for (int k = 1; k <= 7; k++) begin
         step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 4'(k), 1'b0), 100 + k);
      end
      step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd1, 4'd0, 1'b1), 108);
      step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 4'd0, 1'b0), 109);

      // Same burst but Last on the 8th beat: Last wins, no Timeout.
      for (int k = 1; k <= 7; k++) begin
         step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 4'(k), 1'b0), 110 + k);
      end
      step(mk(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0000, 2'd1, 4'd0, 1'b0), 118);
      step(mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 4'd0, 1'b0), 119);

      // Withdrawal: grant requester 3, it drops Req with Ready low while others request.
      step(mk(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 4'd0, 1'b0), 200);
      step(mk(1'b1, 4'b0111, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 4'd0, 1'b0), 201);
      // pointer now 3, so the search starts at 0
      step(mk(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 4'd0, 1'b0), 202);

      // Reset mid-burst: move to requester 1, transfer 4 beats, reset on beat 5.
      step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0), 300);
      step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 4'd0, 1'b0), 301);
      for (int k = 1; k <= 4; k++) begin
         step(mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 4'(k), 1'b0), 301 + k);
      end
      step(mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 1'b0), 306);
      // pointer restored to N-1, so requester 0 wins
      step(mk(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 4'd0, 1'b0), 307);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
